tx_sym_sched: RTL and testbench

TX_SYM_SCHED -- requirements
Module: tx_sym_sched

---
 rtl/tx_pkg.sv | 24 ++
 rtl/tx_sym_shifter.sv | 32 +++
 rtl/tx_sym_sched.sv | 219 +++++++++++++++++++++
 tb/tb_tx_sym_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the QPSK transmit symbol scheduler.
package tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData,
        StFlush
    } tx_state_e;

    localparam int unsigned UPSAMPLE_DEF     = 4;
    localparam int unsigned NCOEF_DEF        = 24;
    localparam int unsigned PREAMBLE_LEN_DEF = 16;

    // Preamble alternates between these two (I,Q) pairs, starting with A.
    localparam logic [1:0] PRE_SYM_A = 2'b11;
    localparam logic [1:0] PRE_SYM_B = 2'b00;
    localparam logic [1:0] ZERO_SYM  = 2'b00;

    function automatic logic [1:0] pre_sym(input logic odd);
        return odd ? PRE_SYM_B : PRE_SYM_A;
    endfunction

endpackage

// File: rtl/tx_sym_shifter.sv
// Byte-to-dibit shifter: a load emits bits [7:6] directly and keeps the
// remaining three dibits; each shift exposes the next one, MSB first.
module tx_sym_shifter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       shift_i,
    output logic [1:0] sym_o,
    output logic       empty_o
);

    logic [7:0] sreg_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            sreg_q <= {data_i[5:0], 2'b00};
            cnt_q  <= 2'd3;
        end else if (shift_i && (cnt_q != 2'd0)) begin
            sreg_q <= {sreg_q[5:0], 2'b00};
            cnt_q  <= cnt_q - 2'd1;
        end
    end

    assign sym_o   = sreg_q[7:6];
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/tx_sym_sched.sv
// QPSK transmit symbol scheduler: frames a byte stream into preamble, data and
// flush symbols. Define TX_SYM_SCHED_PREAMBLE_EN to include the preamble.
module tx_sym_sched
    import tx_pkg::*;
#(
    parameter int unsigned UPSAMPLE     = UPSAMPLE_DEF,
    parameter int unsigned NCOEF        = NCOEF_DEF,
    parameter int unsigned PREAMBLE_LEN = PREAMBLE_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_last,
    output logic                        sym_i,
    output logic                        sym_q,
    output logic                        sym_stb,
    output logic [$clog2(UPSAMPLE)-1:0] phase,
    output logic                        tx_active,
    output logic                        underrun
);

    localparam int unsigned PHW       = $clog2(UPSAMPLE);
    localparam int unsigned FLUSH_LEN = NCOEF / UPSAMPLE;
    localparam int unsigned FCW       = $clog2(FLUSH_LEN + 1);

    if ((UPSAMPLE < 2) || ((UPSAMPLE & (UPSAMPLE - 1)) != 0)) begin : g_bad_upsample
        $error("UPSAMPLE must be a power of two, at least 2");
    end
    if (PREAMBLE_LEN < 1) begin : g_bad_preamble
        $error("PREAMBLE_LEN must be at least 1");
    end
    if (FLUSH_LEN < 1) begin : g_bad_flush
        $error("NCOEF must be at least UPSAMPLE");
    end

    tx_state_e        state_q, state_d;
    logic [PHW-1:0]   phase_q;
    logic             boundary;

    logic [7:0]       hold_data_q;
    logic             hold_last_q;
    logic             hold_valid_q;
    logic             take;

    logic             byte_last_q, byte_last_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [1:0]       pair_q, pair_d;
    logic             tx_active_q, tx_active_d;
    logic             underrun_q, underrun_d;
    logic             sym_stb_q;

    logic             sh_load, sh_shift, sh_empty;
    logic [1:0]       sh_sym;
    logic             data_step;

`ifdef TX_SYM_SCHED_PREAMBLE_EN
    localparam int unsigned PCW = $clog2(PREAMBLE_LEN + 1);
    logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
`endif

    assign boundary = (phase_q == PHW'(UPSAMPLE - 1));
    assign s_ready  = ~hold_valid_q;
    assign take     = s_valid & s_ready;

    tx_sym_shifter u_shifter (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (sh_load),
        .data_i  (hold_data_q),
        .shift_i (sh_shift),
        .sym_o   (sh_sym),
        .empty_o (sh_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= '0;
            sym_stb_q <= 1'b0;
        end else begin
            phase_q   <= phase_q + 1'b1;
            sym_stb_q <= boundary;
        end
    end

    // Loads only happen while the register is full, captures only while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
        end else if (take) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= s_data;
            hold_last_q  <= s_last;
        end else if (sh_load) begin
            hold_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_last_q <= 1'b0;
            flush_cnt_q <= '0;
            pair_q      <= ZERO_SYM;
            tx_active_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_last_q <= byte_last_d;
            flush_cnt_q <= flush_cnt_d;
            pair_q      <= pair_d;
            tx_active_q <= tx_active_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef TX_SYM_SCHED_PREAMBLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        byte_last_d = byte_last_q;
        flush_cnt_d = flush_cnt_q;
        pair_d      = pair_q;
        tx_active_d = tx_active_q;
        underrun_d  = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        data_step   = 1'b0;
`ifdef TX_SYM_SCHED_PREAMBLE_EN
        pre_cnt_d   = pre_cnt_q;
`endif

        if (boundary) begin
            unique case (state_q)
                StIdle: begin
                    pair_d = ZERO_SYM;
                    if (hold_valid_q) begin
                        tx_active_d = 1'b1;
`ifdef TX_SYM_SCHED_PREAMBLE_EN
                        state_d   = StPreamble;
                        pair_d    = PRE_SYM_A;
                        pre_cnt_d = PCW'(1);
`else
                        state_d   = StData;
                        data_step = 1'b1;
`endif
                    end
                end
                StPreamble: begin
`ifdef TX_SYM_SCHED_PREAMBLE_EN
                    if (pre_cnt_q == PCW'(PREAMBLE_LEN)) begin
                        state_d   = StData;
                        pre_cnt_d = '0;
                        data_step = 1'b1;
                    end else begin
                        pair_d    = pre_sym(pre_cnt_q[0]);
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
`else
                    state_d = StIdle;
`endif
                end
                StData: begin
                    data_step = 1'b1;
                end
                StFlush: begin
                    pair_d = ZERO_SYM;
                    if (flush_cnt_q == FCW'(FLUSH_LEN)) begin
                        state_d     = StIdle;
                        tx_active_d = 1'b0;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Shifter drained: finish the frame, refill, or pad with an underrun.
            if (data_step) begin
                if (!sh_empty) begin
                    sh_shift = 1'b1;
                    pair_d   = sh_sym;
                end else if (byte_last_q) begin
                    state_d     = StFlush;
                    byte_last_d = 1'b0;
                    pair_d      = ZERO_SYM;
                    flush_cnt_d = FCW'(1);
                end else if (hold_valid_q) begin
                    sh_load     = 1'b1;
                    pair_d      = hold_data_q[7:6];
                    byte_last_d = hold_last_q;
                end else begin
                    pair_d     = ZERO_SYM;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    assign sym_i     = pair_q[1];
    assign sym_q     = pair_q[0];
    assign sym_stb   = sym_stb_q;
    assign phase     = phase_q;
    assign tx_active = tx_active_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_tx_sym_sched.sv
// Scoreboard bench for tx_sym_sched: expected symbols are queued as stimulus is
// issued and a monitor checks each active symbol strobe against the queue.
module tb_tx_sym_sched;

    localparam int unsigned UPS  = 4;
    localparam int unsigned NCO  = 24;
    localparam int unsigned PLEN = 16;
    localparam int unsigned FLEN = NCO / UPS;
`ifdef TX_SYM_SCHED_PREAMBLE_EN
    localparam int PRE_CYC = UPS * PLEN;
`else
    localparam int PRE_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       sym_i, sym_q, sym_stb, tx_active, underrun;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2:0] exp_q[$];

    tx_sym_sched #(
        .UPSAMPLE     (UPS),
        .NCOEF        (NCO),
        .PREAMBLE_LEN (PLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_stb   (sym_stb),
        .phase     (phase),
        .tx_active (tx_active),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sym(input logic i, input logic q, input logic u);
        exp_q.push_back({i, q, u});
    endtask

    task automatic push_pre();
`ifdef TX_SYM_SCHED_PREAMBLE_EN
        for (int k = 0; k < int'(PLEN); k++) push_sym(k % 2 == 0, k % 2 == 0, 1'b0);
`endif
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 3; k >= 0; k--) push_sym(b[2*k+1], b[2*k], 1'b0);
    endtask

    task automatic push_flush();
        for (int k = 0; k < int'(FLEN); k++) push_sym(1'b0, 1'b0, 1'b0);
    endtask

    // Returns at the falling edge of a cycle whose phase is 0.
    task automatic align();
        for (int k = 0; k < 2 * int'(UPS); k++) begin
            @(negedge clk);
            if (phase == 2'd0) return;
        end
        checks++;
        errors++;
        $display("FAIL align: phase 0 not seen, got %0d", phase);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        s_data  = b;
        s_last  = l;
        s_valid = 1'b1;
        for (int k = 0; k < 300 && !s_ready; k++) @(negedge clk);
        check("s_ready_wait", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        for (int k = 0; k < 800 && exp_q.size() != 0; k++) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        for (int k = 0; k < 2 * int'(UPS) && !sym_stb; k++) @(negedge clk);
        check({name, "_idle_after_flush"}, {sym_stb, tx_active, sym_i, sym_q}, 4'b1000);
    endtask

    // Monitor: strobe period, symbol scoreboard, outputs steady between strobes.
    initial begin
        int         gap;
        logic       seen;
        logic [2:0] prev;
        logic [2:0] e;
        gap  = 0;
        seen = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap  = 0;
                seen = 1'b0;
                prev = '0;
            end else begin
                gap++;
                if (sym_stb) begin
                    if (seen) check("stb_period", gap, UPS);
                    seen = 1'b1;
                    gap  = 0;
                    if (tx_active) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_symbol: got %b%b u=%b, queue empty",
                                     sym_i, sym_q, underrun);
                        end else begin
                            e = exp_q.pop_front();
                            check("symbol", {sym_i, sym_q, underrun}, e);
                        end
                    end
                end else begin
                    check("underrun_off_strobe", underrun, 0);
                    check("steady_between_strobes", {sym_i, sym_q, tx_active}, prev);
                end
                prev = {sym_i, sym_q, tx_active};
            end
        end
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {sym_i, sym_q, sym_stb, tx_active, underrun}, 0);
        check("reset_phase", phase, 0);
        check("reset_s_ready", s_ready, 1);
        rst = 1'b0;

        // Single byte 0xB4 with last: (1,0),(1,1),(0,1),(0,0) then flush.
        push_pre();
        push_byte(8'hB4);
        push_flush();
        align();
        send_byte(8'hB4, 1'b1);
        finish_frame("b4");

        // Back-to-back 0xFF, 0x00: no gap symbols.
        push_pre();
        push_byte(8'hFF);
        push_byte(8'h00);
        push_flush();
        align();
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b1);
        finish_frame("ff00");

        // 0x1B with last: (0,0),(0,1),(1,0),(1,1).
        push_pre();
        push_byte(8'h1B);
        push_flush();
        align();
        send_byte(8'h1B, 1'b1);
        finish_frame("1b");

        // 0xAA, then a 12-cycle gap after its last symbol: three pad symbols.
        push_pre();
        push_byte(8'hAA);
        repeat (3) push_sym(1'b0, 1'b0, 1'b1);
        push_byte(8'h55);
        push_flush();
        align();
        send_byte(8'hAA, 1'b0);
        repeat (27 + PRE_CYC) @(negedge clk);
        send_byte(8'h55, 1'b1);
        finish_frame("underrun");

        // Reset mid-DATA at cycle 37 of the frame, right after one pad symbol.
        push_pre();
        push_byte(8'hC3);
        push_byte(8'h3C);
        push_sym(1'b0, 1'b0, 1'b1);
        align();
        t0 = cyc;
        send_byte(8'hC3, 1'b0);
        send_byte(8'h3C, 1'b0);
        for (int k = 0; k < 400 && cyc < t0 + 37 + PRE_CYC; k++) @(negedge clk);
        check("mid_frame_active", tx_active, 1);
        check("pre_reset_drained", exp_q.size(), 0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {sym_i, sym_q, sym_stb, tx_active, underrun, phase}, 0);
        check("async_reset_s_ready", s_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (UPS) @(negedge clk);
        check("first_stb_after_reset", {sym_stb, tx_active, phase}, 4'b1000);

        push_pre();
        push_byte(8'h1B);
        push_flush();
        align();
        send_byte(8'h1B, 1'b1);
        finish_frame("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
